// File: rtl/cios_gamma_ctrl_if.sv
// Bus bundle between the CIOS inner-loop controller, the outer sequencer,
// the T/p register files and the gamma PE.
// The controller uses the master modport and its environment uses the slave modport.
interface cios_gamma_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
);
    // outer sequencer side
    logic             start;
    logic [WIDTH-1:0] m_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] carry_out;
    // register file side
    logic [AW-1:0]    t_raddr;
    logic [WIDTH-1:0] t_rdata;
    logic [AW-1:0]    p_raddr;
    logic [WIDTH-1:0] p_rdata;
    logic             t_we;
    logic [AW-1:0]    t_waddr;
    logic [WIDTH-1:0] t_wdata;
    // gamma PE side
    logic             pe_en;
    logic [WIDTH-1:0] pe_Cin;
    logic [WIDTH-1:0] pe_Sin;
    logic [WIDTH-1:0] pe_m;
    logic [WIDTH-1:0] pe_pj;
    logic [WIDTH-1:0] pe_Cout;
    logic [WIDTH-1:0] pe_Sout;

    modport master (
        input  start, m_in, t_rdata, p_rdata, pe_Cout, pe_Sout,
        output busy, done, carry_out, t_raddr, p_raddr, t_we, t_waddr, t_wdata,
               pe_en, pe_Cin, pe_Sin, pe_m, pe_pj
    );

    modport slave (
        output start, m_in, t_rdata, p_rdata, pe_Cout, pe_Sout,
        input  busy, done, carry_out, t_raddr, p_raddr, t_we, t_waddr, t_wdata,
               pe_en, pe_Cin, pe_Sin, pe_m, pe_pj
    );
endinterface

// File: rtl/cios_gamma_ctrl.sv
// CIOS inner j-loop controller: walks limbs 0..NWORDS-1 through one gamma PE,
// holding the PE inputs steady for PE_LAT enabled cycles per limb, then
// capturing the carry and writing Sout back one limb lower (word shift).
module cios_gamma_ctrl #(
    parameter  int WIDTH  = 32,
    parameter  int NWORDS = 8,
    parameter  int PE_LAT = 3,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    cios_gamma_ctrl_if.master bus
);

    localparam int CW = $clog2(PE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [AW-1:0]    r_j;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cntNext;
    logic [WIDTH-1:0] r_carry;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_carryOut;
    logic             w_lastLimb;
    logic             w_peEn;
    logic             w_tWe;

    assign w_cntNext  = r_cnt + CW'(1);
    assign w_lastLimb = (r_j == AW'(NWORDS - 1));

    // State register; reset drops straight back to IDLE so no further writes occur
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: one ISSUE, PE_LAT-1 WAITs, one WRITE per limb
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_nextState = (PE_LAT > 1) ? WAIT : WRITE;
            end
            WAIT: begin
                if (w_cntNext == CW'(PE_LAT)) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                w_nextState = w_lastLimb ? DONE : ISSUE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Loop datapath: limb index, enable counter, running carry, latched m and final carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j        <= '0;
            r_cnt      <= '0;
            r_carry    <= '0;
            r_m        <= '0;
            r_carryOut <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.m_in;
                        r_j     <= '0;
                        r_carry <= '0;
                    end
                end
                ISSUE: begin
                    r_cnt <= CW'(1);
                end
                WAIT: begin
                    r_cnt <= w_cntNext;
                end
                WRITE: begin
                    r_carry <= bus.pe_Cout;
                    if (w_lastLimb) begin
                        // updated here so carry_out is already valid while done is high
                        r_carryOut <= bus.pe_Cout;
                    end else begin
                        r_j <= r_j + AW'(1);
                    end
                end
                DONE: begin
                    r_carryOut <= r_carry;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign w_peEn = (r_state == ISSUE) || (r_state == WAIT);
    assign w_tWe  = (r_state == WRITE) && (r_j != '0);

    // Output decode; data/address buses are forced to zero when not in use
    always_comb begin
        bus.busy      = (r_state == ISSUE) || (r_state == WAIT) || (r_state == WRITE);
        bus.done      = (r_state == DONE);
        bus.carry_out = r_carryOut;
        bus.pe_en     = w_peEn;
        bus.t_raddr   = '0;
        bus.p_raddr   = '0;
        bus.pe_Cin    = '0;
        bus.pe_Sin    = '0;
        bus.pe_m      = '0;
        bus.pe_pj     = '0;
        bus.t_we      = w_tWe;
        bus.t_waddr   = '0;
        bus.t_wdata   = '0;
        if (w_peEn) begin
            bus.t_raddr = r_j;
            bus.p_raddr = r_j;
            bus.pe_Cin  = r_carry;
            bus.pe_Sin  = bus.t_rdata;
            bus.pe_m    = r_m;
            bus.pe_pj   = bus.p_rdata;
        end
        if (w_tWe) begin
            bus.t_waddr = r_j - AW'(1);
            bus.t_wdata = bus.pe_Sout;
        end
    end

endmodule
